// File: rtl/pipe_pkg.sv
// pipe_pkg: shared IR field positions, forward-select codes and hazard match helper
package pipe_pkg;
  localparam int RS_LSB = 5;
  localparam int RT_LSB = 0;
  localparam int RD_LSB = 10;
  localparam int SA_LSB = 15;
  localparam int IMM_LSB = 10;
  localparam int OP_LSB = 20;
  localparam logic [31:0] NOP = 32'h0;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_EX = 2'b01, FWD_MEM = 2'b10, FWD_WB = 2'b11} fwd_e;
  function automatic logic hit(input logic use_src, input logic [4:0] src, input logic wreg, input logic [4:0] wn);
    return use_src && src != 5'd0 && wreg && wn == src;
  endfunction
endpackage

// File: rtl/pipe_fwd_regfile.sv
// pipe_fwd_regfile: REG_N x DATA_W register file, two read ports, one write port with write-through
//   clk/clrn: clock, async active-high reset; ra_i/rb_i -> qa_o/qb_o: read ports
//   we_i/wn_i/wd_i: write port; indices >= REG_N read 0 and are never written; r0 is hardwired 0
module pipe_fwd_regfile #(
  parameter int DATA_W = 32,
  parameter int REG_N = 32
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [4:0]        ra_i,
  input  logic [4:0]        rb_i,
  output logic [DATA_W-1:0] qa_o,
  output logic [DATA_W-1:0] qb_o,
  input  logic              we_i,
  input  logic [4:0]        wn_i,
  input  logic [DATA_W-1:0] wd_i
);
  localparam int AW = $clog2(REG_N);
  logic [DATA_W-1:0] regs_q [REG_N];
  logic wr, ra_ok, rb_ok;
  assign wr = we_i && wn_i != 5'd0 && {1'b0, wn_i} < 6'(REG_N);
  assign ra_ok = {1'b0, ra_i} < 6'(REG_N);
  assign rb_ok = {1'b0, rb_i} < 6'(REG_N);
  assign qa_o = (wr && wn_i == ra_i) ? wd_i : ra_ok ? regs_q[ra_i[AW-1:0]] : '0;
  assign qb_o = (wr && wn_i == rb_i) ? wd_i : rb_ok ? regs_q[rb_i[AW-1:0]] : '0;
  always_ff @(posedge clk or posedge clrn)
    if (clrn) regs_q <= '{default: '0};
    else if (wr) regs_q[wn_i[AW-1:0]] <= wd_i;
endmodule

// File: rtl/pipe_fwd_id_stage.sv
// pipe_fwd_id_stage: decode stage with IR, register file, EX/MEM/WB forwarding, RAW stall and flush
//   inputs: IF instruction/valid, flush, control-unit decode bits, EX/MEM/WB destination + data
//   outputs: decoded fields, forwarded operands, forward selects, id_valid, if_wip, stall_cnt
module pipe_fwd_id_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N = 32,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [31:0]       if_inst,
  input  logic              if_valid,
  input  logic              flush,
  input  logic              use_rs,
  input  logic              use_rt,
  input  logic              sext,
  input  logic              shift,
  input  logic              sst,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic [4:0]        ex_wn,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic              mem_wreg,
  input  logic [4:0]        mem_wn,
  input  logic [DATA_W-1:0] mem_fwd,
  input  logic              wb_wreg,
  input  logic [4:0]        wb_wn,
  input  logic [DATA_W-1:0] wb_data,
  output logic [11:0]       id_op,
  output logic [4:0]        id_rs,
  output logic [4:0]        id_rt,
  output logic [4:0]        id_wn,
  output logic [DATA_W-1:0] id_qa,
  output logic [DATA_W-1:0] id_qb,
  output logic [DATA_W-1:0] id_imm,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_valid,
  output logic              if_wip,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [31:0] ir_q, ir_d;
  logic valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] rs, rt, rd, sa;
  logic [15:0] imm;
  logic [DATA_W-1:0] rf_a, rf_b;
  logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b, raw_stall, stall;
  assign rs = ir_q[RS_LSB +: 5];
  assign rt = ir_q[RT_LSB +: 5];
  assign rd = ir_q[RD_LSB +: 5];
  assign sa = ir_q[SA_LSB +: 5];
  assign imm = ir_q[IMM_LSB +: 16];
  pipe_fwd_regfile #(.DATA_W(DATA_W), .REG_N(REG_N)) u_rf (
    .clk(clk), .clrn(clrn), .ra_i(rs), .rb_i(rt), .qa_o(rf_a), .qb_o(rf_b),
    .we_i(wb_wreg), .wn_i(wb_wn), .wd_i(wb_data)
  );
  assign ex_a = hit(use_rs, rs, ex_wreg, ex_wn);
  assign ex_b = hit(use_rt, rt, ex_wreg, ex_wn);
  assign mem_a = hit(use_rs, rs, mem_wreg, mem_wn);
  assign mem_b = hit(use_rt, rt, mem_wreg, mem_wn);
  assign wb_a = hit(use_rs, rs, wb_wreg, wb_wn);
  assign wb_b = hit(use_rt, rt, wb_wreg, wb_wn);
  // Without forwarding, any EX/MEM producer must drain to WB before ID may proceed.
  assign raw_stall = FWD_EN ? (ex_a | ex_b) & ex_m2reg : ex_a | ex_b | mem_a | mem_b;
  assign stall = raw_stall & valid_q & ~flush;
  always_comb begin
    fwd_a = (FWD_EN && ex_a) ? FWD_EX : (FWD_EN && mem_a) ? FWD_MEM : wb_a ? FWD_WB : FWD_RF;
    fwd_b = (FWD_EN && ex_b) ? FWD_EX : (FWD_EN && mem_b) ? FWD_MEM : wb_b ? FWD_WB : FWD_RF;
    id_qa = fwd_a == FWD_EX ? ex_alu : fwd_a == FWD_MEM ? mem_fwd : fwd_a == FWD_WB ? wb_data : rf_a;
    id_qb = fwd_b == FWD_EX ? ex_alu : fwd_b == FWD_MEM ? mem_fwd : fwd_b == FWD_WB ? wb_data : rf_b;
    ir_d = flush ? NOP : stall ? ir_q : if_inst;
    valid_d = ~flush & (stall ? valid_q : if_valid);
    cnt_d = cnt_q + CNT_W'(stall & ~&cnt_q);
  end
  always_ff @(posedge clk or posedge clrn)
    if (clrn) begin
      ir_q <= NOP;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ir_q <= ir_d;
      valid_q <= valid_d;
      cnt_q <= cnt_d;
    end
  assign id_op = ir_q[OP_LSB +: 12];
  assign id_rs = rs;
  assign id_rt = rt;
  assign id_wn = sst ? rt : rd;
  assign id_imm = shift ? {{(DATA_W-5){1'b0}}, sa} : {{(DATA_W-16){sext & imm[15]}}, imm};
  assign id_valid = valid_q & ~stall & ~flush;
  assign if_wip = ~stall;
  assign stall_cnt = cnt_q;
endmodule

// File: doc/pipe_fwd_id_stage.md
# pipe_fwd_id_stage

Parametrised instruction-decode stage for the 5-stage pipeline: instruction register, register file with write-through bypass, operand forwarding from EX/MEM/WB, load-use stall generation and branch flush. Successor to the stall-only decode stage: width and register count are parameters, and a mode parameter selects forwarding or full RAW stalling. Sits between the IF stage and the ID/EX pipeline register. Decoded control comes from the combinational control unit, which reads `id_op`.

## Interface
- `DATA_W`, 32, datapath and register width
- `REG_N`, 32, register count (power of two); `AW = $clog2(REG_N)`, must be ≤ 5 (field width)
- `FWD_EN`, 1, 1 = forward from EX/MEM; 0 = stall on any EX/MEM RAW match
- `CNT_W`, 16, stall-counter width

Ports:
- `clk`  in  1  clock, rising edge
- `clrn`  in  1  reset, asynchronous, active-high
- `if_inst`  in  32  fetched instruction
- `if_valid`  in  1  fetched instruction valid
- `flush`  in  1  branch redirect; kill instruction in ID
- `use_rs`, `use_rt`  in  1  control unit: instruction reads rs / rt
- `sext`, `shift`, `sst`  in  1  control unit: sign-extend, shift-amount operand, write to rt
- `ex_wreg`, `ex_m2reg`  in  1  EX writes reg / EX is a load
- `ex_wn`  in  5  EX destination
- `ex_alu`  in  DATA_W  EX result
- `mem_wreg`  in  1  MEM writes reg
- `mem_wn`  in  5  MEM destination
- `mem_fwd`  in  DATA_W  MEM result (ALU or load data, muxed upstream)
- `wb_wreg`  in  1  WB write enable
- `wb_wn`  in  5  WB destination
- `wb_data`  in  DATA_W  WB data
- `id_op`  out  12  inst[31:20]
- `id_rs`, `id_rt`, `id_wn`  out  5  sources; destination (rd if `sst`=0, else rt)
- `id_qa`, `id_qb`  out  DATA_W  forwarded operands
- `id_imm`  out  DATA_W  extended imm[25:10] or zero-extended sa[19:15]
- `fwd_a`, `fwd_b`  out  2  source select: 00 RF, 01 EX, 10 MEM, 11 WB
- `id_valid`  out  1  ID holds a live instruction passing downstream this cycle
- `if_wip`  out  1  PC / IR write enable (= ~stall)
- `stall_cnt`  out  CNT_W  saturating stall-cycle count

## Operation
- IR fields: rs=[9:5], rt=[4:0], rd=[14:10], sa=[19:15], imm=[25:10], op=[31:20]. Register index uses low AW bits; index ≥ REG_N reads 0 and never writes.
- IR update priority: `flush` → IR=0, valid=0; else stall → hold; else IR=`if_inst`, valid=`if_valid`.
- Register file: reg 0 reads 0; write at edge when `wb_wreg` and `wb_wn`≠0; same-cycle read of `wb_wn` returns `wb_data` (code 11).
- Match(src, stage) = `use_src` & src≠0 & stage_wreg & stage_wn==src. Priority EX > MEM > WB > RF.
- FWD_EN=1: EX match with `ex_m2reg` → stall; otherwise EX/MEM matches forward.
- FWD_EN=0: any EX or MEM match → stall; codes 01/10 never produced.
- stall = raw_stall & valid & ~flush. During stall: `if_wip`=0, `id_valid`=0 (bubble to EX), IR held.
- `id_valid` = valid & ~stall & ~flush.
- `id_imm`: `shift` → {0, sa}; else {DATA_W-16 copies of (`sext`&imm[15]), imm}.
- `stall_cnt` increments each stall cycle, saturates at all-ones, never wraps.

## Timing
- IF→ID: one cycle. All `id_*`, `fwd_*`, `if_wip` are combinational from IR and bypass inputs.
- Reset: IR=0, valid=0, all registers=0, `stall_cnt`=0, `id_valid`=0, `if_wip`=1, `fwd_*`=00, `id_qa`/`id_qb`/`id_imm`=0.
- Reset mid-stall: stall drops immediately; counter cleared.
- `flush` with stall: flush wins; IR cleared, no bubble counted.
- Load-use stall lasts exactly one cycle (load moves to MEM, then forwards via code 10).

## Structure
- Package `pipe_pkg`: IR field bit positions, forward codes `FWD_RF/EX/MEM/WB`, NOP=32'h0.
- Sub-module `pipe_fwd_regfile` (parametrised REG_N×DATA_W, two read ports, write-through bypass).

## Test plan
- Reset, then `if_inst` rs=3, rt=4, WB writes r3=0x11 → next cycle `id_qa`=0x11, `fwd_a`=11.
- EX add r5 (`ex_alu`=0xAA), ID reads rs=5, FWD_EN=1 → `fwd_a`=01, `id_qa`=0xAA, `if_wip`=1.
- EX load r6 (`ex_m2reg`=1), ID reads rt=6 → one cycle `if_wip`=0, `id_valid`=0, `stall_cnt`=1; next cycle `fwd_b`=10.
- FWD_EN=0, MEM writes r7, ID reads r7 → stall until WB, then `fwd_*`=11.
- EX/MEM/WB all write r0, ID reads r0 → `id_qa`=0, `fwd_a`=00, no stall.
- `flush` during load-use stall → IR=0, `id_valid`=0, `stall_cnt` unchanged; CNT_W=2 forced 5 stalls → `stall_cnt`=3.
